mbscore_alu_operand_stage: RTL and testbench

//  Parametrised ALU operand-select stage between decode/regfile read and the ALU.
//  - Builds ALU operands A and B from register data, an extended immediate, or a shamt field.
//  - Resolves RAW hazards via NUM_FWD forwarding ports.
//  - Registers results into a 2-entry skid buffer with valid/ready on both sides,
//    so the stage holds full throughput while the ALU stalls.

---
 rtl/mbscore_alu_operand_stage_pkg.sv | 19 +
 rtl/mbscore_alu_operand_stage_if.sv | 43 ++++
 rtl/mbscore_skid_buffer.sv | 77 +++++++
 rtl/mbscore_alu_operand_stage.sv | 77 +++++++
 tb/tb_mbscore_alu_operand_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mbscore_alu_operand_stage_pkg.sv
// Shared widths and operand-select codes for the ALU operand stage.
package mbscore_alu_operand_stage_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int IMM_WIDTH      = 16;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_SEL_WIDTH  = 3;
  localparam int FWD_PORTS      = 2;

  typedef enum logic [ALU_SEL_WIDTH-1:0] {
    ALU_SEL_REG    = 3'd0,
    ALU_SEL_IMM_ZX = 3'd1,
    ALU_SEL_IMM_SX = 3'd2,
    ALU_SEL_IMM_HI = 3'd3,
    ALU_SEL_SHAMT  = 3'd4,
    ALU_SEL_ZERO   = 3'd5
  } alu_sel_e;

endpackage

// File: rtl/mbscore_alu_operand_stage_if.sv
// Decode-side and ALU-side signals of the operand stage, grouped as one bundle.
// Handshake: a transfer happens on a rising edge where valid && ready; a producer
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface mbscore_alu_operand_stage_if
  import mbscore_alu_operand_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int IMM_W   = IMM_WIDTH,
  parameter int SEL_W   = ALU_SEL_WIDTH,
  parameter int RADDR_W = REG_ADDR_WIDTH,
  parameter int NUM_FWD = FWD_PORTS
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [IMM_W-1:0]           imm;
  logic [SEL_W-1:0]           sel_a;
  logic [SEL_W-1:0]           sel_b;
  logic [RADDR_W-1:0]         rs_addr;
  logic [RADDR_W-1:0]         rt_addr;
  logic [DATA_W-1:0]          rs_data;
  logic [DATA_W-1:0]          rt_data;
  logic [NUM_FWD-1:0]         fwd_valid;
  logic [NUM_FWD*RADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0]  fwd_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          alu_a;
  logic [DATA_W-1:0]          alu_b;

  modport master (
    output flush, in_valid, imm, sel_a, sel_b, rs_addr, rt_addr, rs_data, rt_data,
           fwd_valid, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b
  );

  modport slave (
    input  flush, in_valid, imm, sel_a, sel_b, rs_addr, rt_addr, rs_data, rt_data,
           fwd_valid, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b
  );

endinterface

// File: rtl/mbscore_skid_buffer.sv
// Two-entry FIFO skid buffer. The head register drives the output directly, so it
// keeps the last popped value while empty; in_ready is registered from next count.
module mbscore_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic             push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_data;
          else                 tail_d = in_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves this cycle; the older tail (if any) moves up ahead of the new entry.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = in_data;
          end else begin
            head_d = in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/mbscore_alu_operand_stage.sv
// ALU operand-select stage: forwards RAW hazards, extends immediates, selects A/B
// and hands the pair to the ALU through a 2-entry skid buffer.
module mbscore_alu_operand_stage
  import mbscore_alu_operand_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int IMM_W   = IMM_WIDTH,
  parameter int SEL_W   = ALU_SEL_WIDTH,
  parameter int RADDR_W = REG_ADDR_WIDTH,
  parameter int NUM_FWD = FWD_PORTS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mbscore_alu_operand_stage_if.slave   bus,
  output logic [1:0]                   count
);

  logic [DATA_W-1:0] rs_res, rt_res;
  logic [DATA_W-1:0] imm_zx, imm_sx, imm_hi, imm_sh;
  logic [DATA_W-1:0] op_a, op_b;

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] zx,
    input logic [DATA_W-1:0] sx,
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] sh
  );
    case (sel)
      ALU_SEL_REG:    return reg_val;
      ALU_SEL_IMM_ZX: return zx;
      ALU_SEL_IMM_SX: return sx;
      ALU_SEL_IMM_HI: return hi;
      ALU_SEL_SHAMT:  return sh;
      default:        return '0;
    endcase
  endfunction

  // Walk from oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    rs_res = bus.rs_data;
    rt_res = bus.rt_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_valid[i] && (bus.rs_addr != '0) &&
          (bus.fwd_addr[i*RADDR_W +: RADDR_W] == bus.rs_addr))
        rs_res = bus.fwd_data[i*DATA_W +: DATA_W];
      if (bus.fwd_valid[i] && (bus.rt_addr != '0) &&
          (bus.fwd_addr[i*RADDR_W +: RADDR_W] == bus.rt_addr))
        rt_res = bus.fwd_data[i*DATA_W +: DATA_W];
    end
  end

  assign imm_zx = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
  assign imm_sx = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign imm_hi = {bus.imm, {(DATA_W-IMM_W){1'b0}}};
  assign imm_sh = {{(DATA_W-5){1'b0}}, bus.imm[10:6]};

  assign op_a = pick_operand(bus.sel_a, rs_res, imm_zx, imm_sx, imm_hi, imm_sh);
  assign op_b = pick_operand(bus.sel_b, rt_res, imm_zx, imm_sx, imm_hi, imm_sh);

  mbscore_skid_buffer #(
    .WIDTH (2*DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({op_a, op_b}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  ({bus.alu_a, bus.alu_b}),
    .count     (count)
  );

endmodule

// File: tb/tb_mbscore_alu_operand_stage.sv
// Directed bench for the ALU operand stage: operand select, forwarding, stall,
// streaming, flush and asynchronous reset.
module tb_mbscore_alu_operand_stage;
  import mbscore_alu_operand_stage_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] count;
  int         errors;
  int         checks;
  logic [31:0] exp_q[$];

  mbscore_alu_operand_stage_if bus ();

  mbscore_alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.imm       = '0;
    bus.sel_a     = 3'd0;
    bus.sel_b     = 3'd0;
    bus.rs_addr   = '0;
    bus.rt_addr   = '0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.fwd_valid = '0;
    bus.fwd_addr  = '0;
    bus.fwd_data  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive_op(input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] imm,
                          input logic [4:0] rsa, input logic [31:0] rsd,
                          input logic [4:0] rta, input logic [31:0] rtd);
    bus.in_valid = 1'b1;
    bus.sel_a    = sa;
    bus.sel_b    = sb;
    bus.imm      = imm;
    bus.rs_addr  = rsa;
    bus.rs_data  = rsd;
    bus.rt_addr  = rta;
    bus.rt_data  = rtd;
  endtask

  task automatic set_fwd(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    bus.fwd_valid = v;
    bus.fwd_addr  = {a1, a0};
    bus.fwd_data  = {d1, d0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %h want 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_b: got %h want 0", bus.alu_b); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_select();
    logic [2:0]  sa_t [6] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd2, 3'd3};
    logic [2:0]  sb_t [6] = '{3'd2, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2};
    logic [15:0] imm_t[6] = '{16'hFFF0, 16'h8421, 16'h8421, 16'h8421, 16'h7FFF, 16'h0001};
    logic [31:0] ea_t [6] = '{32'h5, 32'h0000_8421, 32'h10, 32'h0, 32'h0000_7FFF, 32'h0001_0000};
    logic [31:0] eb_t [6] = '{32'hFFFF_FFF0, 32'h8421_0000, 32'h0, 32'h0, 32'h1234, 32'h1};
    bus.out_ready = 1'b1;
    set_fwd(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      drive_op(sa_t[k], sb_t[k], imm_t[k], 5'd1, 32'h5, 5'd2, 32'h1234);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid[%0d]: got %b want 1", k, bus.out_valid); end
      checks++; if (bus.alu_a !== ea_t[k]) begin errors++; $display("FAIL sel_alu_a[%0d]: got %h want %h", k, bus.alu_a, ea_t[k]); end
      checks++; if (bus.alu_b !== eb_t[k]) begin errors++; $display("FAIL sel_alu_b[%0d]: got %h want %h", k, bus.alu_b, eb_t[k]); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h0001_0000) begin errors++; $display("FAIL sel_hold_alu_a: got %h want 00010000", bus.alu_a); end
  endtask

  task automatic test_forward();
    logic [4:0]  rsa_t[5] = '{5'd3, 5'd3, 5'd0, 5'd5, 5'd7};
    logic [4:0]  rta_t[5] = '{5'd3, 5'd4, 5'd0, 5'd6, 5'd7};
    logic [1:0]  fv_t [5] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [4:0]  fa0_t[5] = '{5'd3, 5'd3, 5'd0, 5'd5, 5'd7};
    logic [4:0]  fa1_t[5] = '{5'd3, 5'd4, 5'd0, 5'd5, 5'd7};
    logic [31:0] ea_t [5] = '{32'hAA, 32'h11, 32'h11, 32'hAA, 32'h11};
    logic [31:0] eb_t [5] = '{32'hAA, 32'hBB, 32'h22, 32'h22, 32'h22};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_fwd(fv_t[k], fa0_t[k], fa1_t[k], 32'hAA, 32'hBB);
      drive_op(3'd0, 3'd0, 16'h0, rsa_t[k], 32'h11, rta_t[k], 32'h22);
      @(negedge clk);
      checks++; if (bus.alu_a !== ea_t[k]) begin errors++; $display("FAIL fwd_alu_a[%0d]: got %h want %h", k, bus.alu_a, ea_t[k]); end
      checks++; if (bus.alu_b !== eb_t[k]) begin errors++; $display("FAIL fwd_alu_b[%0d]: got %h want %h", k, bus.alu_b, eb_t[k]); end
    end
    bus.in_valid = 1'b0;
    set_fwd(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h111, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid1: got %b want 1", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h111) begin errors++; $display("FAIL stall_a1: got %h want 111", bus.alu_a); end
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h222, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready2: got %b want 0", bus.in_ready); end
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL stall_count2: got %0d want 2", count); end
    checks++; if (bus.alu_a !== 32'h111) begin errors++; $display("FAIL stall_a2: got %h want 111", bus.alu_a); end
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h333, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready3: got %b want 0", bus.in_ready); end
    checks++; if (bus.alu_a !== 32'h111) begin errors++; $display("FAIL stall_a3: got %h want 111", bus.alu_a); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_pop_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h222) begin errors++; $display("FAIL stall_pop_a: got %h want 222", bus.alu_a); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_pop_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h222) begin errors++; $display("FAIL stall_empty_hold: got %h want 222", bus.alu_a); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        exp = exp_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, bus.out_valid); end
        checks++; if (bus.alu_a !== exp) begin errors++; $display("FAIL b2b_alu_a[%0d]: got %h want %h", k, bus.alu_a, exp); end
      end
      if (k < 8) begin
        drive_op(3'd0, 3'd1, 16'(k), 5'd9, 32'h100 + 32'(k), 5'd0, 32'h0);
        exp_q.push_back(32'h100 + 32'(k));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h444, 5'd0, 32'h0);
    @(negedge clk);
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h555, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    bus.flush = 1'b1;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h666, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b want 1", bus.in_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_full_count: got %0d want 0", count); end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_after: got %b want 0", bus.out_valid); end
    // flush while an accept really happens: the accepted op must be dropped
    bus.out_ready = 1'b0;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h777, 5'd0, 32'h0);
    @(negedge clk);
    bus.flush = 1'b1;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h888, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_acc_valid: got %b want 0", bus.out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_acc_count: got %0d want 0", count); end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive_op(3'd0, 3'd5, 16'h0, 5'd1, 32'h999, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h999) begin errors++; $display("FAIL flush_next_a: got %h want 999", bus.alu_a); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_next_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive_op(3'd0, 3'd1, 16'hBEEF, 5'd1, 32'hDEAD, 5'd0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_a !== 32'hDEAD) begin errors++; $display("FAIL arst_pre_a: got %h want dead", bus.alu_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("FAIL arst_alu_a: got %h want 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("FAIL arst_alu_b: got %h want 0", bus.alu_b); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_select();
    test_forward();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
